// File: rtl/intersection_ctrl_if.sv
// Control inputs and lamp outputs of the two-approach intersection sequencer.
// The sequencer takes the slave side; whoever drives requests and watches the lamps takes the master side.
interface intersection_ctrl_if #(parameter int W = 4);
  logic         Set;
  logic         Stop;
  logic         Emg;
  logic         PedNS;
  logic         PedEW;
  logic [W-1:0] Gin;
  logic [W-1:0] Yin;
  logic [W-1:0] Cin;
  logic         NSG;
  logic         NSY;
  logic         NSR;
  logic         EWG;
  logic         EWY;
  logic         EWR;
  logic         WalkNS;
  logic         WalkEW;
  logic [2:0]   Phase;

  modport master (
    output Set, Stop, Emg, PedNS, PedEW, Gin, Yin, Cin,
    input  NSG, NSY, NSR, EWG, EWY, EWR, WalkNS, WalkEW, Phase
  );

  modport slave (
    input  Set, Stop, Emg, PedNS, PedEW, Gin, Yin, Cin,
    output NSG, NSY, NSR, EWG, EWY, EWR, WalkNS, WalkEW, Phase
  );
endinterface

// File: rtl/intersection_ctrl.sv
// Two-approach intersection sequencer with all-red clearance between approaches,
// latched pedestrian walks, emergency preemption and reprogrammable phase durations.
module intersection_ctrl #(
  parameter int           W     = 4,
  parameter logic [W-1:0] DEF_G = 4'd8,
  parameter logic [W-1:0] DEF_Y = 4'd3,
  parameter logic [W-1:0] DEF_C = 4'd2
) (
  input logic                clk,
  input logic                reset,
  intersection_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    CLR_A   = 3'd0,
    NS_G    = 3'd1,
    NS_Y    = 3'd2,
    CLR_B   = 3'd3,
    EW_G    = 3'd4,
    EW_Y    = 3'd5,
    EMG     = 3'd6,
    ILLEGAL = 3'd7
  } state_t;

  state_t       state, state_n;
  logic [W-1:0] cnt, cnt_n;
  logic [W-1:0] gd, gd_n, yd, yd_n, cd, cd_n;
  logic         req_ns, req_ns_n, req_ew, req_ew_n;
  logic         walk_ns, walk_ns_n, walk_ew, walk_ew_n;
  logic [W-1:0] dur, last;
  state_t       succ;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= CLR_A;
      cnt     <= '0;
      gd      <= DEF_G;
      yd      <= DEF_Y;
      cd      <= DEF_C;
      req_ns  <= 1'b0;
      req_ew  <= 1'b0;
      walk_ns <= 1'b0;
      walk_ew <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      gd      <= gd_n;
      yd      <= yd_n;
      cd      <= cd_n;
      req_ns  <= req_ns_n;
      req_ew  <= req_ew_n;
      walk_ns <= walk_ns_n;
      walk_ew <= walk_ew_n;
    end
  end

  // A programmed duration of zero behaves as one cycle, so the exit count is clamped at 0.
  always_comb begin
    case (state)
      NS_G, EW_G: dur = gd;
      NS_Y, EW_Y: dur = yd;
      default:    dur = cd;
    endcase
    last = (dur == '0) ? '0 : dur - W'(1);
  end

  always_comb begin
    case (state)
      CLR_A:   succ = NS_G;
      NS_G:    succ = NS_Y;
      NS_Y:    succ = CLR_B;
      CLR_B:   succ = EW_G;
      EW_G:    succ = EW_Y;
      EW_Y:    succ = CLR_A;
      default: succ = CLR_A;
    endcase
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    gd_n      = gd;
    yd_n      = yd;
    cd_n      = cd;
    req_ns_n  = req_ns | bus.PedNS;
    req_ew_n  = req_ew | bus.PedEW;
    walk_ns_n = walk_ns;
    walk_ew_n = walk_ew;

    if (bus.Set) begin
      gd_n     = bus.Gin;
      yd_n     = bus.Yin;
      cd_n     = bus.Cin;
      state_n  = CLR_A;
      cnt_n    = '0;
      req_ns_n = 1'b0;
      req_ew_n = 1'b0;
    end else if (bus.Emg) begin
      state_n = EMG;
      cnt_n   = '0;
    end else if (state == EMG || state == ILLEGAL) begin
      state_n = CLR_A;
      cnt_n   = '0;
    end else if (bus.Stop) begin
      state_n = state;
      cnt_n   = cnt;
    end else if (cnt == last) begin
      state_n = succ;
      cnt_n   = '0;
    end else begin
      cnt_n = cnt + W'(1);
    end

    // The latch is consumed on green entry; a request arriving on that same edge waits for the next green.
    if (state_n == NS_G && state != NS_G) begin
      walk_ns_n = req_ns;
      req_ns_n  = bus.PedNS;
    end else if (state_n != NS_G) begin
      walk_ns_n = 1'b0;
    end

    if (state_n == EW_G && state != EW_G) begin
      walk_ew_n = req_ew;
      req_ew_n  = bus.PedEW;
    end else if (state_n != EW_G) begin
      walk_ew_n = 1'b0;
    end
  end

  // Lamps decode straight from the state register; every non-green, non-yellow state is all red.
  always_comb begin
    bus.NSG    = (state == NS_G);
    bus.NSY    = (state == NS_Y);
    bus.NSR    = !(state == NS_G || state == NS_Y);
    bus.EWG    = (state == EW_G);
    bus.EWY    = (state == EW_Y);
    bus.EWR    = !(state == EW_G || state == EW_Y);
    bus.WalkNS = walk_ns;
    bus.WalkEW = walk_ew;
    bus.Phase  = state;
  end

endmodule
